out_word_uart_tx: RTL and testbench

Output-side stage that consumes the processor's 32-bit `OUT` word and transmits it off-chip over a UART line (8N1). A change of `OUT` is captured into a small FIFO. Each captured word is sent as 4 bytes, least-significant byte first. The block sits directly downstream of `risc_v` and is instantiated next to it at the top level.

---
 rtl/out_tx_pkg.sv | 13 +
 rtl/out_word_fifo.sv | 69 ++++++
 rtl/out_word_uart_tx.sv | 142 ++++++++++++++
 tb/tb_out_word_uart_tx.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/out_tx_pkg.sv
// Shared types and constants for the OUT-word UART transmitter.
package out_tx_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } tx_state_e;

  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/out_word_fifo.sv
// Word FIFO between change detect and the UART serialiser.
module out_word_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic [LW-1:0]    level,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             push_ok, pop_ok;

  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  // A pop frees the slot on the same edge, so a full FIFO can still take a push.
  assign push_ok = push && (!full || pop);
  assign pop_ok  = pop && !empty;
  assign rd_data = mem_q[rd_ptr_q];
  assign level   = level_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push_ok && !pop_ok) begin
      level_d = level_q + 1'b1;
    end else if (!push_ok && pop_ok) begin
      level_d = level_q - 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge CLK) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/out_word_uart_tx.sv
// Captures changes of the processor OUT word and sends each as 4 bytes (LSB first) over 8N1 UART.
//   state   | meaning
//   S_IDLE  | line high, waiting for a queued word
//   S_START | start bit (low)
//   S_DATA  | 8 data bits of the current byte, LSB first
//   S_STOP  | stop bit (high); then next byte or back to idle
module out_word_uart_tx
  import out_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [31:0]                 OUT_DATA,
  output logic                        TX,
  output logic                        BUSY,
  output logic [$clog2(FIFO_DEPTH):0] FIFO_LEVEL,
  output logic                        OVERFLOW
);

  localparam int CW = $clog2(CLKS_PER_BIT);

  tx_state_e         state_q, state_d;
  logic [CW-1:0]     clk_cnt_q, clk_cnt_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [31:0]       shreg_q, shreg_d;
  logic [31:0]       last_seen_q, last_seen_d;
  logic              tx_q, tx_d;
  logic              overflow_q, overflow_d;
  logic              push_req, pop, bit_end;
  logic [7:0]        cur_byte;
  logic [31:0]       fifo_rd_data;
  logic              fifo_full, fifo_empty;

  out_word_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .CLK     (CLK),
    .RST     (RST),
    .push    (push_req),
    .pop     (pop),
    .wr_data (OUT_DATA),
    .rd_data (fifo_rd_data),
    .level   (FIFO_LEVEL),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign push_req    = (OUT_DATA != last_seen_q);
  assign last_seen_d = OUT_DATA;
  assign overflow_d  = overflow_q | (push_req & fifo_full & ~pop);
  assign bit_end     = (clk_cnt_q == CW'(CLKS_PER_BIT - 1));

  always_comb begin
    state_d    = state_q;
    clk_cnt_d  = clk_cnt_q;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    shreg_d    = shreg_q;
    pop        = 1'b0;
    if (state_q != S_IDLE) begin
      clk_cnt_d = bit_end ? '0 : clk_cnt_q + 1'b1;
    end
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          shreg_d    = fifo_rd_data;
          byte_idx_d = '0;
          bit_idx_d  = '0;
          clk_cnt_d  = '0;
          state_d    = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          bit_idx_d = '0;
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (byte_idx_q != 2'(BYTES_PER_WORD - 1)) begin
            shreg_d    = shreg_q >> 8;
            byte_idx_d = byte_idx_q + 1'b1;
            state_d    = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // TX is registered from the next-state view so the line changes cleanly on the edge.
    cur_byte = shreg_d[7:0];
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = cur_byte[bit_idx_d];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= S_IDLE;
      clk_cnt_q   <= '0;
      bit_idx_q   <= '0;
      byte_idx_q  <= '0;
      shreg_q     <= '0;
      last_seen_q <= '0;
      tx_q        <= 1'b1;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      clk_cnt_q   <= clk_cnt_d;
      bit_idx_q   <= bit_idx_d;
      byte_idx_q  <= byte_idx_d;
      shreg_q     <= shreg_d;
      last_seen_q <= last_seen_d;
      tx_q        <= tx_d;
      overflow_q  <= overflow_d;
    end
  end

  assign TX       = tx_q;
  assign OVERFLOW = overflow_q;
  assign BUSY     = (state_q != S_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_out_word_uart_tx.sv
// Directed and randomized checks of out_word_uart_tx against an arithmetic line-waveform model.
module tb_out_word_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 40 * CPB;

  logic        clk;
  logic        rst_n;
  logic [31:0] out_data;
  logic        tx;
  logic        busy;
  logic [2:0]  fifo_level;
  logic        overflow;

  int tests = 0;
  int fails = 0;

  logic [31:0] exp_q [$];
  logic [31:0] model_last;

  out_word_uart_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .CLK        (clk),
    .RST        (rst_n),
    .OUT_DATA   (out_data),
    .TX         (tx),
    .BUSY       (busy),
    .FIFO_LEVEL (fifo_level),
    .OVERFLOW   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive a new OUT word; the model queues it only when it differs from the previous one.
  task automatic drive(input logic [31:0] w);
    out_data = w;
    if (w != model_last) exp_q.push_back(w);
    model_last = w;
  endtask

  function automatic logic [31:0] next_rand();
    logic [31:0] w;
    w = $urandom;
    while (w == model_last) w = $urandom;
    return w;
  endfunction

  // Expected line level t cycles into a word frame: 4 x (start, 8 data LSB first, stop).
  function automatic logic line_bit(input logic [31:0] w, input int t);
    int k;
    int p;
    k = t / CPB;
    p = k % 10;
    if (p == 0) return 1'b0;
    if (p == 9) return 1'b1;
    return w[(k / 10) * 8 + p - 1];
  endfunction

  // Called at the negedge of frame cycle 'start'; returns at the negedge of cycle FRAME.
  task automatic check_frame(input string tag, input int start);
    logic [31:0] w;
    logic [31:0] rx;
    int bad;
    if (exp_q.size() == 0) begin
      $display("FAIL %s: no expected word queued", tag);
      $fatal(1, "expected queue empty");
    end
    w   = exp_q.pop_front();
    rx  = '0;
    bad = 0;
    for (int t = start; t < FRAME; t++) begin
      int k;
      k = t / CPB;
      if (tx !== line_bit(w, t)) bad++;
      if ((k % 10) >= 1 && (k % 10) <= 8 && (t % CPB) == CPB / 2)
        rx[(k / 10) * 8 + (k % 10) - 1] = tx;
      @(negedge clk);
    end
    chk($sformatf("%s_data", tag), rx, w);
    chk($sformatf("%s_wave_errs", tag), 32'(bad), 32'd0);
  endtask

  task automatic frames(input string tag, input int n, input int start);
    for (int i = 0; i < n; i++) begin
      check_frame($sformatf("%s_w%0d", tag, i), (i == 0) ? start : 0);
      if (i < n - 1) begin
        chk($sformatf("%s_gap%0d", tag, i), 32'(tx), 32'd1);
        @(negedge clk);
      end
    end
    chk($sformatf("%s_end_busy", tag), 32'(busy), 32'd0);
    chk($sformatf("%s_end_tx", tag), 32'(tx), 32'd1);
  endtask

  task automatic send_one(input string tag, input logic [31:0] w);
    drive(w);
    @(negedge clk);
    chk($sformatf("%s_lvl", tag), 32'(fifo_level), 32'd1);
    chk($sformatf("%s_tx_hold", tag), 32'(tx), 32'd1);
    @(negedge clk);
    frames(tag, 1, 0);
  endtask

  initial begin
    int bad;
    int ovf_lvl [6];
    logic [31:0] w;

    ovf_lvl    = '{1, 1, 2, 3, 4, 4};
    rst_n      = 1'b0;
    out_data   = '0;
    model_last = '0;

    #12;
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_lvl", 32'(fifo_level), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Zero after reset is not a change.
    bad = 0;
    repeat (500) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || fifo_level !== 3'd0) bad++;
    end
    chk("nochange_errs", 32'(bad), 32'd0);
    chk("nochange_lvl", 32'(fifo_level), 32'd0);

    send_one("single", 32'h12345678);

    // Six consecutive changes from idle: the sixth finds the FIFO full.
    drive(32'h1);
    @(negedge clk);
    chk("ovf_lvl1", 32'(fifo_level), 32'(ovf_lvl[0]));
    for (int i = 2; i <= 6; i++) begin
      drive(32'(i));
      @(negedge clk);
      chk($sformatf("ovf_lvl%0d", i), 32'(fifo_level), 32'(ovf_lvl[i-1]));
    end
    chk("ovf_flag", 32'(overflow), 32'd1);
    void'(exp_q.pop_back());
    frames("ovf", 5, 4);
    chk("ovf_sticky", 32'(overflow), 32'd1);

    // Reset during the 10th bit of a word, with a second word still queued.
    drive(32'hA5A5A5A5);
    @(negedge clk);
    @(negedge clk);
    w = next_rand();
    drive(w);
    @(negedge clk);
    drive(32'hA5A5A5A5);
    @(negedge clk);
    chk("rstmid_lvl_pre", 32'(fifo_level), 32'd2);
    repeat (36) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid_tx", 32'(tx), 32'd1);
    chk("rstmid_lvl", 32'(fifo_level), 32'd0);
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_ovf", 32'(overflow), 32'd0);
    exp_q.delete();
    model_last = '0;
    @(negedge clk);
    rst_n = 1'b1;
    drive(32'hA5A5A5A5);
    @(negedge clk);
    chk("rstmid_resend_lvl", 32'(fifo_level), 32'd1);
    @(negedge clk);
    frames("rstmid_resend", 1, 0);

    // FIFO full while the current word ends; push on the pop edge.
    drive(next_rand());
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      drive(next_rand());
      @(negedge clk);
    end
    chk("full_lvl_pre", 32'(fifo_level), 32'd4);
    check_frame("full_w0", 4);
    chk("full_gap", 32'(tx), 32'd1);
    chk("full_lvl_idle", 32'(fifo_level), 32'd4);
    drive(next_rand());
    @(negedge clk);
    chk("full_lvl_pop", 32'(fifo_level), 32'd4);
    chk("full_ovf", 32'(overflow), 32'd0);
    frames("full", 5, 0);
    chk("full_ovf_end", 32'(overflow), 32'd0);

    // Only equality with the immediately previous value is suppressed.
    drive(32'h5);
    @(negedge clk);
    drive(32'h7);
    @(negedge clk);
    drive(32'h5);
    @(negedge clk);
    chk("rep_lvl", 32'(fifo_level), 32'd2);
    frames("rep", 3, 1);

    for (int i = 0; i < 3; i++) begin
      send_one($sformatf("rnd%0d", i), next_rand());
    end

    drive(next_rand());
    @(negedge clk);
    drive(next_rand());
    @(negedge clk);
    chk("rpair_lvl", 32'(fifo_level), 32'd1);
    frames("rpair", 2, 0);

    // Reset while the line is low in a start bit.
    drive(next_rand());
    @(negedge clk);
    @(negedge clk);
    chk("rststart_pre_tx", 32'(tx), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("rststart_tx", 32'(tx), 32'd1);
    chk("rststart_busy", 32'(busy), 32'd0);
    chk("rststart_lvl", 32'(fifo_level), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
